// File: rtl/cc_bus_initiator.sv
// Initiator for the external parallel memory/peripheral bus: turns one internal
// read/write request at a time into a registered CS/RD/WR strobe sequence.
module cc_bus_initiator #(
    parameter int ADDR_WIDTH  = 16,
    parameter int DATA_WIDTH  = 8,
    parameter int WAIT_STATES = 2,
    parameter int TURNAROUND  = 1
) (
    input  logic                  clk,
    input  logic                  reset_n,
    input  logic                  req,
    input  logic                  wr,
    input  logic [ADDR_WIDTH-1:0] addr,
    input  logic [DATA_WIDTH-1:0] wdata,
    output logic                  ready,
    output logic                  done,
    output logic [DATA_WIDTH-1:0] rdata,
    output logic                  rdata_valid,
    output logic [ADDR_WIDTH-1:0] bus_addr,
    output logic [DATA_WIDTH-1:0] bus_data_out,
    input  logic [DATA_WIDTH-1:0] bus_data_in,
    output logic                  bus_data_oe,
    output logic                  bus_cs_n,
    output logic                  bus_rd_n,
    output logic                  bus_wr_n
);

    typedef enum logic [2:0] {
        S_IDLE,
        S_SETUP,
        S_STROBE,
        S_HOLD,
        S_TURN
    } state_t;

    localparam logic [7:0] WAIT_LOAD = 8'(WAIT_STATES);
    localparam logic [7:0] TURN_LOAD = 8'(TURNAROUND - 1);

    state_t                state, state_nx;
    logic [7:0]            cnt, cnt_nx;
    logic                  is_wr, is_wr_nx;
    logic                  done_nx, rdata_valid_nx;
    logic [DATA_WIDTH-1:0] rdata_nx;
    logic [ADDR_WIDTH-1:0] bus_addr_nx;
    logic [DATA_WIDTH-1:0] bus_data_out_nx;
    logic                  bus_data_oe_nx, bus_cs_n_nx, bus_rd_n_nx, bus_wr_n_nx;

    assign ready = (state == S_IDLE);

    // Next values of every registered output are formed here, so the pins are
    // pure flops and req never reaches them combinationally.
    always_comb begin
        state_nx        = state;
        cnt_nx          = cnt;
        is_wr_nx        = is_wr;
        done_nx         = done;
        rdata_valid_nx  = rdata_valid;
        rdata_nx        = rdata;
        bus_addr_nx     = bus_addr;
        bus_data_out_nx = bus_data_out;
        bus_data_oe_nx  = bus_data_oe;
        bus_cs_n_nx     = bus_cs_n;
        bus_rd_n_nx     = bus_rd_n;
        bus_wr_n_nx     = bus_wr_n;

        case (state)
            S_IDLE: begin
                if (req) begin
                    is_wr_nx       = wr;
                    bus_addr_nx    = addr;
                    bus_cs_n_nx    = 1'b0;
                    bus_data_oe_nx = wr;
                    if (wr) bus_data_out_nx = wdata;
                    state_nx       = S_SETUP;
                end
            end
            S_SETUP: begin
                if (is_wr) bus_wr_n_nx = 1'b0;
                else       bus_rd_n_nx = 1'b0;
                cnt_nx   = WAIT_LOAD;
                state_nx = S_STROBE;
            end
            S_STROBE: begin
                if (cnt == 8'd0) begin
                    bus_rd_n_nx    = 1'b1;
                    bus_wr_n_nx    = 1'b1;
                    if (!is_wr) rdata_nx = bus_data_in;
                    done_nx        = 1'b1;
                    rdata_valid_nx = ~is_wr;
                    state_nx       = S_HOLD;
                end else begin
                    cnt_nx = cnt - 8'd1;
                end
            end
            S_HOLD: begin
                bus_cs_n_nx    = 1'b1;
                bus_data_oe_nx = 1'b0;
                done_nx        = 1'b0;
                rdata_valid_nx = 1'b0;
                if (TURNAROUND == 0) begin
                    state_nx = S_IDLE;
                end else begin
                    cnt_nx   = TURN_LOAD;
                    state_nx = S_TURN;
                end
            end
            S_TURN: begin
                if (cnt == 8'd0) state_nx = S_IDLE;
                else             cnt_nx   = cnt - 8'd1;
            end
            default: state_nx = S_IDLE;
        endcase
    end

    // NOTE: state uses non-blocking assignments so every flop samples the
    // pre-edge values; blocking here would create order-dependent races.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state        <= S_IDLE;
            cnt          <= 8'd0;
            is_wr        <= 1'b0;
            done         <= 1'b0;
            rdata_valid  <= 1'b0;
            rdata        <= '0;
            bus_addr     <= '0;
            bus_data_out <= '0;
            bus_data_oe  <= 1'b0;
            bus_cs_n     <= 1'b1;
            bus_rd_n     <= 1'b1;
            bus_wr_n     <= 1'b1;
        end else begin
            state        <= state_nx;
            cnt          <= cnt_nx;
            is_wr        <= is_wr_nx;
            done         <= done_nx;
            rdata_valid  <= rdata_valid_nx;
            rdata        <= rdata_nx;
            bus_addr     <= bus_addr_nx;
            bus_data_out <= bus_data_out_nx;
            bus_data_oe  <= bus_data_oe_nx;
            bus_cs_n     <= bus_cs_n_nx;
            bus_rd_n     <= bus_rd_n_nx;
            bus_wr_n     <= bus_wr_n_nx;
        end
    end

endmodule

// File: tb/tb_cc_bus_initiator.sv
// Randomised bench for cc_bus_initiator: a default-timing instance and a
// zero-wait/zero-turnaround instance, checked cycle by cycle against a timing model.
module tb_cc_bus_initiator;

    logic        clk = 1'b0;
    logic        reset_n;
    logic        req, wr;
    logic [15:0] addr;
    logic [7:0]  wdata, bus_data_in;
    logic        sel;   // 0: default instance, 1: fast instance

    logic        a_ready, a_done, a_rv, a_oe, a_cs_n, a_rd_n, a_wr_n;
    logic [7:0]  a_rdata, a_dout;
    logic [15:0] a_baddr;
    logic        b_ready, b_done, b_rv, b_oe, b_cs_n, b_rd_n, b_wr_n;
    logic [7:0]  b_rdata, b_dout;
    logic [15:0] b_baddr;

    int checks = 0;
    int errors = 0;

    logic [7:0]  exp_rdata [2];
    logic [7:0]  exp_dout  [2];
    logic [15:0] exp_addr  [2];

    always #5 clk = ~clk;

    cc_bus_initiator #(.ADDR_WIDTH(16), .DATA_WIDTH(8), .WAIT_STATES(2), .TURNAROUND(1)) dut_a (
        .clk(clk), .reset_n(reset_n), .req(req & ~sel), .wr(wr), .addr(addr), .wdata(wdata),
        .ready(a_ready), .done(a_done), .rdata(a_rdata), .rdata_valid(a_rv),
        .bus_addr(a_baddr), .bus_data_out(a_dout), .bus_data_in(bus_data_in),
        .bus_data_oe(a_oe), .bus_cs_n(a_cs_n), .bus_rd_n(a_rd_n), .bus_wr_n(a_wr_n)
    );

    cc_bus_initiator #(.ADDR_WIDTH(16), .DATA_WIDTH(8), .WAIT_STATES(0), .TURNAROUND(0)) dut_b (
        .clk(clk), .reset_n(reset_n), .req(req & sel), .wr(wr), .addr(addr), .wdata(wdata),
        .ready(b_ready), .done(b_done), .rdata(b_rdata), .rdata_valid(b_rv),
        .bus_addr(b_baddr), .bus_data_out(b_dout), .bus_data_in(bus_data_in),
        .bus_data_oe(b_oe), .bus_cs_n(b_cs_n), .bus_rd_n(b_rd_n), .bus_wr_n(b_wr_n)
    );

    // Control vector order: {cs_n, rd_n, wr_n, oe, done, rdata_valid, ready}
    logic [6:0]  o_ctrl;
    logic [15:0] o_addr;
    logic [7:0]  o_dout, o_rdata;
    assign o_ctrl  = sel ? {b_cs_n, b_rd_n, b_wr_n, b_oe, b_done, b_rv, b_ready}
                         : {a_cs_n, a_rd_n, a_wr_n, a_oe, a_done, a_rv, a_ready};
    assign o_addr  = sel ? b_baddr : a_baddr;
    assign o_dout  = sel ? b_dout  : a_dout;
    assign o_rdata = sel ? b_rdata : a_rdata;

    localparam logic [6:0] IDLE_CTRL = 7'b1110001;

    function automatic int ws_of(input logic s);
        return s ? 0 : 2;
    endfunction

    function automatic int ta_of(input logic s);
        return s ? 0 : 1;
    endfunction

    // One transaction, starting at a negedge where the selected instance is ready.
    // mode: 0 quiet, 1 random busy noise, 2 req pulse with addr BEEF, 3 directed read data.
    // Returns at the negedge where ready is back, so a following call is back-to-back.
    task automatic do_txn(input logic t_wr, input logic [15:0] t_addr,
                          input logic [7:0] t_wdata, input int mode, input string tag);
        int         ws, ta, last;
        logic [7:0] cap;
        logic [6:0] exp_ctrl;
        ws   = ws_of(sel);
        ta   = ta_of(sel);
        last = ws + 4 + ta;
        cap  = 8'h00;

        checks++;
        if (o_ctrl[0] !== 1'b1) begin
            errors++;
            $display("FAIL %s ready_before_accept got %b exp 1", tag, o_ctrl[0]);
        end

        req = 1'b1; wr = t_wr; addr = t_addr; wdata = t_wdata;
        bus_data_in = (mode == 3) ? 8'hFF : 8'($urandom);
        exp_addr[sel] = t_addr;
        if (t_wr) exp_dout[sel] = t_wdata;

        for (int k = 1; k <= last; k++) begin
            @(negedge clk);
            if (!t_wr && k >= ws + 3) exp_rdata[sel] = cap;
            exp_ctrl = {!(k <= ws + 3),
                        !(!t_wr && k >= 2 && k <= ws + 2),
                        !( t_wr && k >= 2 && k <= ws + 2),
                        t_wr && k <= ws + 3,
                        k == ws + 3,
                        !t_wr && k == ws + 3,
                        k == last};
            checks++;
            if (o_ctrl !== exp_ctrl) begin
                errors++;
                $display("FAIL %s ctrl k=%0d got %b exp %b", tag, k, o_ctrl, exp_ctrl);
            end
            checks++;
            if (o_addr !== exp_addr[sel]) begin
                errors++;
                $display("FAIL %s bus_addr k=%0d got %h exp %h", tag, k, o_addr, exp_addr[sel]);
            end
            checks++;
            if (o_dout !== exp_dout[sel]) begin
                errors++;
                $display("FAIL %s bus_data_out k=%0d got %h exp %h", tag, k, o_dout, exp_dout[sel]);
            end
            checks++;
            if (o_rdata !== exp_rdata[sel]) begin
                errors++;
                $display("FAIL %s rdata k=%0d got %h exp %h", tag, k, o_rdata, exp_rdata[sel]);
            end

            if (mode == 3) bus_data_in = (k == ws + 2) ? 8'h3C : 8'hFF;
            else           bus_data_in = 8'($urandom);
            if (k == ws + 2) cap = bus_data_in;

            if (k == last) begin
                req = 1'b0;
            end else if (mode == 1) begin
                req = 1'($urandom); wr = 1'($urandom);
                addr = 16'($urandom); wdata = 8'($urandom);
            end else if (mode == 2) begin
                req  = (k == 2);
                addr = (k == 2) ? 16'hBEEF : t_addr;
            end else begin
                req = 1'b0;
            end
        end
    endtask

    task automatic idle_cycles(input int n, input string tag);
        for (int i = 0; i < n; i++) begin
            req = 1'b0;
            @(negedge clk);
            checks++;
            if (o_ctrl !== IDLE_CTRL) begin
                errors++;
                $display("FAIL %s idle_ctrl got %b exp %b", tag, o_ctrl, IDLE_CTRL);
            end
            checks++;
            if (o_addr !== exp_addr[sel] || o_dout !== exp_dout[sel] || o_rdata !== exp_rdata[sel]) begin
                errors++;
                $display("FAIL %s idle_hold got %h/%h/%h exp %h/%h/%h", tag, o_addr, o_dout,
                         o_rdata, exp_addr[sel], exp_dout[sel], exp_rdata[sel]);
            end
        end
    endtask

    task automatic clear_model();
        for (int s = 0; s < 2; s++) begin
            exp_rdata[s] = 8'h00;
            exp_dout[s]  = 8'h00;
            exp_addr[s]  = 16'h0000;
        end
    endtask

    task automatic test_reset();
        reset_n = 1'b1; req = 1'b0; wr = 1'b0; addr = '0; wdata = '0;
        bus_data_in = 8'h00; sel = 1'b0;
        #1 reset_n = 1'b0;
        clear_model();
        repeat (2) @(negedge clk);
        for (int s = 0; s < 2; s++) begin
            sel = 1'(s);
            #1;
            checks++;
            if (o_ctrl !== IDLE_CTRL || o_addr !== 16'h0 || o_dout !== 8'h0 || o_rdata !== 8'h0) begin
                errors++;
                $display("FAIL reset_state inst=%0d got %b %h %h %h exp %b 0000 00 00",
                         s, o_ctrl, o_addr, o_dout, o_rdata, IDLE_CTRL);
            end
        end
        sel = 1'b0;
        @(negedge clk);
        reset_n = 1'b1;
        idle_cycles(2, "post_reset");
    endtask

    task automatic test_write();
        sel = 1'b0;
        do_txn(1'b1, 16'h1234, 8'hA5, 0, "write");
        idle_cycles(2, "write_after");
    endtask

    task automatic test_read();
        sel = 1'b0;
        do_txn(1'b0, 16'h4321, 8'h00, 3, "read");
        idle_cycles(1, "read_after");
    endtask

    task automatic test_back_to_back();
        sel = 1'b0;
        do_txn(1'b1, 16'h0F0F, 8'h5A, 0, "b2b_wr");
        do_txn(1'b0, 16'hF0F0, 8'h00, 0, "b2b_rd");
        do_txn(1'b1, 16'h0001, 8'hC3, 0, "b2b_wr2");
        idle_cycles(1, "b2b_after");
    endtask

    task automatic test_busy_ignore();
        sel = 1'b0;
        do_txn(1'b1, 16'h2222, 8'h77, 2, "busy_beef");
        idle_cycles(2, "busy_after");
    endtask

    task automatic test_fast();
        sel = 1'b1;
        do_txn(1'b0, 16'hABCD, 8'h00, 3, "fast_read");
        do_txn(1'b1, 16'hDCBA, 8'h99, 0, "fast_write");
        idle_cycles(1, "fast_after");
        sel = 1'b0;
    endtask

    task automatic test_random();
        for (int n = 0; n < 40; n++) begin
            sel = 1'($urandom_range(0, 1));
            do_txn(1'($urandom), 16'($urandom), 8'($urandom), int'($urandom_range(0, 1)), "random");
            idle_cycles(int'($urandom_range(0, 2)), "random_gap");
        end
        sel = 1'b0;
    endtask

    task automatic test_reset_mid();
        sel = 1'b0;
        req = 1'b1; wr = 1'b1; addr = 16'h5A5A; wdata = 8'hC3;
        @(negedge clk);
        req = 1'b0;
        repeat (2) @(negedge clk);  // now inside STROBE with wr_n low
        checks++;
        if (o_ctrl !== 7'b0101000) begin
            errors++;
            $display("FAIL reset_mid_pre got %b exp 0101000", o_ctrl);
        end
        #2 reset_n = 1'b0;
        #1;
        clear_model();
        checks++;
        if (o_ctrl !== IDLE_CTRL || o_addr !== 16'h0 || o_dout !== 8'h0 || o_rdata !== 8'h0) begin
            errors++;
            $display("FAIL reset_mid got %b %h %h %h exp %b 0000 00 00",
                     o_ctrl, o_addr, o_dout, o_rdata, IDLE_CTRL);
        end
        @(negedge clk);
        reset_n = 1'b1;
        idle_cycles(3, "reset_mid_after");
        do_txn(1'b0, 16'h6666, 8'h00, 0, "reset_recover");
        idle_cycles(1, "recover_after");
    endtask

    initial begin
        test_reset();
        test_write();
        test_read();
        test_back_to_back();
        test_busy_ignore();
        test_fast();
        test_random();
        test_reset_mid();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
